if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues in-order fetch requests to instruction memory,
//  and queues returned instructions with their PCs. Presents one {pc,inst} per cycle to the
//  IF/ID pipeline register through a valid/ready pair.

---
 rtl/if_fetch_unit_pkg.sv | 17 +
 rtl/if_fetch_unit_fetch_queue.sv | 100 ++++++++++
 rtl/if_fetch_unit.sv | 103 ++++++++++
 tb/tb_if_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Imported by the fetch queue and by the fetch unit itself.
package if_fetch_unit_pkg;

   localparam int unsigned PC_WIDTH_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned INST_WIDTH   = 32;
   localparam int unsigned PC_STEP      = 4;

   typedef struct packed {
      logic push;
      logic fill;
      logic pop;
      logic flush;
   } fq_ctrl_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Circular buffer of {pc, inst, filled}: entries are pushed at request time,
// filled in order as responses return, and popped from the head once filled.
module if_fetch_unit_fetch_queue
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned PC_WIDTH = PC_WIDTH_DEF,
   parameter int unsigned DEPTH    = 2,
   localparam int unsigned PTR_W   = $clog2(DEPTH),
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  fq_ctrl_t              ctrl,
   input  logic [PC_WIDTH-1:0]   push_pc,
   input  logic [INST_WIDTH-1:0] fill_inst,
   output logic                  head_filled,
   output logic [PC_WIDTH-1:0]   head_pc,
   output logic [INST_WIDTH-1:0] head_inst,
   output logic [CNT_W-1:0]      count,
   output logic                  has_unfilled
);

   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [PTR_W-1:0]      fill_q, fill_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      unfill_q, unfill_d;
   logic [DEPTH-1:0]      filled_q, filled_d;
   logic [PC_WIDTH-1:0]   pc_mem [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem [DEPTH];

   // NOTE: every variable gets its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      fill_d   = fill_q;
      count_d  = count_q;
      unfill_d = unfill_q;
      filled_d = filled_q;
      if (ctrl.flush) begin
         head_d   = '0;
         tail_d   = '0;
         fill_d   = '0;
         count_d  = '0;
         unfill_d = '0;
         filled_d = '0;
      end else begin
         if (ctrl.push) begin
            tail_d           = tail_q + 1'b1;
            filled_d[tail_q] = 1'b0;
         end
         if (ctrl.fill) begin
            fill_d           = fill_q + 1'b1;
            filled_d[fill_q] = 1'b1;
         end
         if (ctrl.pop) begin
            head_d = head_q + 1'b1;
         end
         count_d  = count_q + CNT_W'(ctrl.push) - CNT_W'(ctrl.pop);
         unfill_d = unfill_q + CNT_W'(ctrl.push) - CNT_W'(ctrl.fill);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of process order.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         count_q  <= '0;
         unfill_q <= '0;
         filled_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         fill_q   <= fill_d;
         count_q  <= count_d;
         unfill_q <= unfill_d;
         filled_q <= filled_d;
      end
   end

   // NOTE: payload storage is deliberately not reset; count/filled gate it, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (ctrl.push && !ctrl.flush) pc_mem[tail_q]   <= push_pc;
      if (ctrl.fill && !ctrl.flush) inst_mem[fill_q] <= fill_inst;
   end

   // Popped entries keep their filled bit, so an empty queue must mask the head.
   assign head_filled  = (count_q != '0) && filled_q[head_q];
   assign head_pc      = pc_mem[head_q];
   assign head_inst    = inst_mem[head_q];
   assign count        = count_q;
   assign has_unfilled = (unfill_q != '0);

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
   a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      (ctrl.push && !ctrl.flush) |-> (count_q < CNT_W'(DEPTH)));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches, tracks outstanding
// requests and stale responses after redirects, and presents {pc, inst} to IF/ID.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int unsigned          PC_WIDTH = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(RESET_PC_DEF),
   parameter int unsigned          DEPTH    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [PC_WIDTH-1:0]   imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [INST_WIDTH-1:0] imem_rsp_data,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [PC_WIDTH-1:0]   if_pc,
   output logic [INST_WIDTH-1:0] if_inst
);

   localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]      out_q, out_d;
   logic [CNT_W-1:0]      drop_q, drop_d;
   fq_ctrl_t              fq_ctrl;
   logic                  head_filled;
   logic [PC_WIDTH-1:0]   head_pc;
   logic [INST_WIDTH-1:0] head_inst;
   logic [CNT_W-1:0]      q_count;
   logic                  has_unfilled;
   logic                  req_fire;
   logic                  rsp_drop;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^redirect_pc[1:0];

   always_comb begin
      imem_req_valid = !rst && !redirect_valid && (q_count < DEPTH_C) && (out_q < DEPTH_C);
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_drop       = imem_rsp_valid && (drop_q != '0);
      if_valid       = !rst && head_filled;

      fq_ctrl.push  = req_fire;
      fq_ctrl.fill  = imem_rsp_valid && !rsp_drop && !redirect_valid;
      fq_ctrl.pop   = if_valid && if_ready;
      fq_ctrl.flush = redirect_valid;

      pc_d   = pc_q;
      out_d  = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      drop_d = drop_q - CNT_W'(rsp_drop);
      // Every request still in flight is stale; a response arriving now is discarded too.
      if (redirect_valid) begin
         pc_d   = {redirect_pc[PC_WIDTH-1:2], 2'b00};
         drop_d = out_q - CNT_W'(imem_rsp_valid);
      end else if (req_fire) begin
         pc_d = pc_q + PC_WIDTH'(PC_STEP);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   if_fetch_unit_fetch_queue #(
      .PC_WIDTH (PC_WIDTH),
      .DEPTH    (DEPTH)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .ctrl         (fq_ctrl),
      .push_pc      (pc_q),
      .fill_inst    (imem_rsp_data),
      .head_filled  (head_filled),
      .head_pc      (head_pc),
      .head_inst    (head_inst),
      .count        (q_count),
      .has_unfilled (has_unfilled)
   );

   assign imem_req_addr = pc_q;
   assign if_pc         = if_valid ? head_pc : '0;
   assign if_inst       = if_valid ? head_inst : '0;

   a_rsp_legal: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> ((drop_q != '0) || has_unfilled));
   a_out_bound: assert property (@(posedge clk) disable iff (rst) out_q <= DEPTH_C);
   a_drop_bound: assert property (@(posedge clk) disable iff (rst) drop_q <= out_q);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a behavioural instruction memory with fixed
// latency, a per-cycle vector table for the streaming case, and hand sequences.
module tb_if_fetch_unit;

   localparam int unsigned PW    = 32;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          redirect_valid = 1'b0;
   logic [PW-1:0] redirect_pc = '0;
   logic          imem_req_valid;
   logic          imem_req_ready = 1'b1;
   logic [PW-1:0] imem_req_addr;
   logic          imem_rsp_valid = 1'b0;
   logic [31:0]   imem_rsp_data = '0;
   logic          if_valid;
   logic          if_ready = 1'b1;
   logic [PW-1:0] if_pc;
   logic [31:0]   if_inst;

   int errors = 0;
   int checks = 0;

   if_fetch_unit #(
      .PC_WIDTH (PW),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Instruction memory: accepts on req fire, answers lat cycles later, in order.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t pend[$];
   int    cyc = 0;
   int    lat = 1;
   int    fire_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         pend.delete();
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + lat});
            fire_cnt <= fire_cnt + 1;
         end
         if (pend.size() > 0 && pend[0].due == cyc) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= inst_of(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int l);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      lat            = l;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_out(input logic [31:0] exp_pc);
      bit got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (if_valid && if_ready) begin
            check("out_pc", if_pc, exp_pc);
            check("out_inst", if_inst, inst_of(exp_pc));
            got = 1'b1;
         end
         step();
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL out_timeout: no output seen, expected pc %h", exp_pc);
      end
   endtask

   typedef struct {
      logic        rv;
      logic [31:0] ra;
      logic        iv;
      logic [31:0] ipc;
   } vec_t;

   vec_t tbl [9];

   initial begin
      // Streaming with 1-cycle memory: no same-cycle bypass when full, so 2 of every 3 cycles deliver.
      tbl[0] = '{rv: 1'b1, ra: 32'h00, iv: 1'b0, ipc: 32'h00};
      tbl[1] = '{rv: 1'b1, ra: 32'h04, iv: 1'b0, ipc: 32'h00};
      tbl[2] = '{rv: 1'b0, ra: 32'h08, iv: 1'b1, ipc: 32'h00};
      tbl[3] = '{rv: 1'b1, ra: 32'h08, iv: 1'b1, ipc: 32'h04};
      tbl[4] = '{rv: 1'b1, ra: 32'h0C, iv: 1'b0, ipc: 32'h00};
      tbl[5] = '{rv: 1'b0, ra: 32'h10, iv: 1'b1, ipc: 32'h08};
      tbl[6] = '{rv: 1'b1, ra: 32'h10, iv: 1'b1, ipc: 32'h0C};
      tbl[7] = '{rv: 1'b1, ra: 32'h14, iv: 1'b0, ipc: 32'h00};
      tbl[8] = '{rv: 1'b0, ra: 32'h18, iv: 1'b1, ipc: 32'h10};

      // Reset state
      step();
      @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_inst", if_inst, 32'd0);
      step();

      // Streaming table
      do_reset(1);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
         check($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].ra);
         check($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].iv));
         check($sformatf("v%0d_if_pc", i), if_pc, tbl[i].ipc);
         if (tbl[i].iv) check($sformatf("v%0d_if_inst", i), if_inst, inst_of(tbl[i].ipc));
         step();
      end

      // IF/ID stall: output held, at most DEPTH requests, no loss on resume
      begin
         int fire0;
         do_reset(1);
         if_ready = 1'b0;
         fire0 = fire_cnt;
         step();
         step();
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc", if_pc, 32'h0);
            check("stall_inst", if_inst, inst_of(32'h0));
            step();
         end
         check("stall_fires", 32'(fire_cnt - fire0), 32'(DEPTH));
         if_ready = 1'b1;
         wait_out(32'h0);
         wait_out(32'h4);
         wait_out(32'h8);
         wait_out(32'hC);
      end

      // Redirect with two stale requests in flight (latency 3)
      do_reset(3);
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_1003;
      @(negedge clk);
      check("redir_no_req", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("redir_addr", imem_req_addr, 32'h0000_1000);
      step();
      wait_out(32'h0000_1000);
      wait_out(32'h0000_1004);

      // Back-to-back redirects, first one coinciding with a response
      do_reset(1);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step();
      redirect_pc    = 32'h0000_0302;
      step();
      redirect_valid = 1'b0;
      wait_out(32'h0000_0300);
      wait_out(32'h0000_0304);

      // Memory back-pressure: request held, pc not advanced
      do_reset(1);
      imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(imem_req_valid), 32'd1);
         check("bp_addr", imem_req_addr, 32'h0);
         step();
      end
      imem_req_ready = 1'b1;
      wait_out(32'h0);
      wait_out(32'h4);

      // PC wrap at the top of the address space
      do_reset(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
      step();
      @(negedge clk);
      check("wrap_addr1", imem_req_addr, 32'h0000_0000);
      step();
      wait_out(32'hFFFF_FFFC);
      wait_out(32'h0000_0000);
      wait_out(32'h0000_0004);

      // Reset mid-stream with a full queue
      do_reset(1);
      if_ready = 1'b0;
      repeat (6) step();
      @(negedge clk);
      check("mid_full_valid", 32'(if_valid), 32'd1);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_if_valid", 32'(if_valid), 32'd0);
      check("mid_rst_if_pc", if_pc, 32'h0);
      check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_if_valid", 32'(if_valid), 32'd0);
      check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      check("post_rst_req_addr", imem_req_addr, 32'h0);
      step();
      if_ready = 1'b1;
      wait_out(32'h0);
      wait_out(32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
